// File: rtl/wb_pkg.sv
// wb_pkg: lane field layout shared by the MEM, ID and WB stages.
// A commit lane is packed as {lv, we, waddr[AW], wdata[DW], pc[32]},
// with pc in the least significant bits. The offset helpers take the
// instantiating stage's AW/DW. The LANE_W constant is for the default
// 32-bit data / 5-bit address configuration.
package wb_pkg;

  localparam int PC_W      = 32;
  localparam int WB_DW     = 32;
  localparam int WB_AW     = 5;

  localparam int PC_OFF    = 0;
  localparam int WDATA_OFF = PC_W;

  function automatic int waddr_off(input int dw);
    return PC_W + dw;
  endfunction

  function automatic int we_off(input int aw, input int dw);
    return PC_W + dw + aw;
  endfunction

  function automatic int lv_off(input int aw, input int dw);
    return PC_W + dw + aw + 1;
  endfunction

  function automatic int lane_w(input int aw, input int dw);
    return 2 + aw + dw + PC_W;
  endfunction

  localparam int LANE_W = lane_w(WB_AW, WB_DW);

endpackage

// File: rtl/wb_waw_mask.sv
// wb_waw_mask: write-after-write suppression inside one commit bundle.
// kill[k] is raised when a younger valid lane j>k writes the same
// register, so only the youngest write of a register reaches the regfile.
// Ports:
//   lv    - per-lane valid (thermometer, lane 0 oldest)
//   we    - per-lane write enable
//   waddr - per-lane destination, lane k at [k*AW +: AW]
//   kill  - per-lane suppress flag
module wb_waw_mask #(
  parameter int LANES = 2,
  parameter int AW    = 5
) (
  input  logic [LANES-1:0]    lv,
  input  logic [LANES-1:0]    we,
  input  logic [LANES*AW-1:0] waddr,
  output logic [LANES-1:0]    kill
);

  always_comb begin
    kill = '0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = k + 1; j < LANES; j++) begin
        if (lv[j] && we[j] && (waddr[j*AW +: AW] == waddr[k*AW +: AW])) begin
          kill[k] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/wb_stage_nway.sv
// wb_stage_nway: N-lane writeback stage.
// Latches a commit bundle from MEM, issues all regfile writes in the first
// cycle the bundle is held, and drives a per-instruction trace port.
// Ports:
//   clk, resetn         - clock, async active-low reset
//   mem_to_wb_valid/bus - bundle offered by MEM (lane k at [k*LANE_W +: LANE_W])
//   wb_allowin          - WB can take a bundle this cycle
//   wb_rf_bus           - per-lane {we, waddr, wdata} to regfile / ID bypass
//   debug_wb_*          - trace port
// Build option WB_TRACE_SERIAL_EN: when defined, the bundle is held one
// cycle per valid lane and the trace walks the lanes in order. When
// undefined, every bundle leaves after one cycle and the trace shows the
// youngest writing lane.
module wb_stage_nway
  import wb_pkg::*;
#(
  parameter int LANES = 2,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic                             mem_to_wb_valid,
  input  logic [LANES*lane_w(AW,DW)-1:0]   mem_to_wb_bus,
  output logic                             wb_allowin,
  output logic [LANES*(1+AW+DW)-1:0]       wb_rf_bus,
  output logic [31:0]                      debug_wb_pc,
  output logic [3:0]                       debug_wb_rf_we,
  output logic [AW-1:0]                    debug_wb_rf_wnum,
  output logic [DW-1:0]                    debug_wb_rf_wdata
);

  localparam int LW   = lane_w(AW, DW);
  localparam int RW   = 1 + AW + DW;
  localparam int IW   = $clog2(LANES) + 1;
  localparam int WA_O = waddr_off(DW);
  localparam int WE_O = we_off(AW, DW);
  localparam int LV_O = lv_off(AW, DW);

  logic                wb_valid_q, wb_valid_d;
  logic                rf_done_q, rf_done_d;
  logic [LANES*LW-1:0] bus_q, bus_d;

  logic                accept;
  logic                ready_go;
  logic [LANES-1:0]    lv, we, kill;
  logic [LANES*AW-1:0] waddr;
  logic [LANES*DW-1:0] wdata;
  logic [LANES*32-1:0] pc;
  logic [IW-1:0]       cnt;

  always_comb begin
    lv    = '0;
    we    = '0;
    waddr = '0;
    wdata = '0;
    pc    = '0;
    cnt   = '0;
    for (int k = 0; k < LANES; k++) begin
      lv[k]              = bus_q[k*LW + LV_O];
      we[k]              = bus_q[k*LW + WE_O];
      waddr[k*AW +: AW]  = bus_q[k*LW + WA_O +: AW];
      wdata[k*DW +: DW]  = bus_q[k*LW + WDATA_OFF +: DW];
      pc[k*32 +: 32]     = bus_q[k*LW + PC_OFF +: 32];
      cnt                = cnt + IW'(lv[k]);
    end
  end

  wb_waw_mask #(.LANES(LANES), .AW(AW)) u_waw_mask (
    .lv    (lv),
    .we    (we),
    .waddr (waddr),
    .kill  (kill)
  );

  assign wb_allowin = ~wb_valid_q | ready_go;
  assign accept     = mem_to_wb_valid & wb_allowin;

  always_comb begin
    bus_d      = accept ? mem_to_wb_bus : bus_q;
    wb_valid_d = wb_allowin ? mem_to_wb_valid : wb_valid_q;
    // rf_done marks that this bundle's writes already went out.
    rf_done_d  = accept ? 1'b0 : (wb_valid_q ? 1'b1 : rf_done_q);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wb_valid_q <= 1'b0;
      rf_done_q  <= 1'b0;
    end else begin
      wb_valid_q <= wb_valid_d;
      rf_done_q  <= rf_done_d;
    end
  end

  // Payload is qualified by wb_valid_q everywhere, so it needs no reset.
  always_ff @(posedge clk) begin
    bus_q <= bus_d;
  end

  always_comb begin
    wb_rf_bus = '0;
    for (int k = 0; k < LANES; k++) begin
      wb_rf_bus[k*RW +: RW] = {lv[k] & we[k] & wb_valid_q & ~rf_done_q & ~kill[k],
                               waddr[k*AW +: AW], wdata[k*DW +: DW]};
    end
  end

`ifdef WB_TRACE_SERIAL_EN
  logic [IW-1:0] idx_q, idx_d;

  assign ready_go = (cnt == '0) || (idx_q == cnt - IW'(1));

  always_comb begin
    if (accept)                       idx_d = '0;
    else if (wb_valid_q && !ready_go) idx_d = idx_q + IW'(1);
    else                              idx_d = idx_q;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) idx_q <= '0;
    else         idx_q <= idx_d;
  end

  // Trace walks lane idx; we is shown unmasked by the WAW kill.
  always_comb begin
    debug_wb_rf_we    = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (wb_valid_q && cnt != '0) begin
      for (int k = 0; k < LANES; k++) begin
        if (IW'(k) == idx_q) begin
          debug_wb_rf_we    = {4{we[k]}};
          debug_wb_pc       = pc[k*32 +: 32];
          debug_wb_rf_wnum  = waddr[k*AW +: AW];
          debug_wb_rf_wdata = wdata[k*DW +: DW];
        end
      end
    end
  end
`else
  assign ready_go = 1'b1;

  // Ascending scan so the youngest writing lane is the one left selected.
  always_comb begin
    debug_wb_rf_we    = '0;
    debug_wb_pc       = '0;
    debug_wb_rf_wnum  = '0;
    debug_wb_rf_wdata = '0;
    if (wb_valid_q && cnt != '0) begin
      for (int k = 0; k < LANES; k++) begin
        if (lv[k] && we[k]) begin
          debug_wb_rf_we    = 4'hf;
          debug_wb_pc       = pc[k*32 +: 32];
          debug_wb_rf_wnum  = waddr[k*AW +: AW];
          debug_wb_rf_wdata = wdata[k*DW +: DW];
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_stage_nway.sv
module tb_wb_stage_nway;

  localparam int LANES = 2;
  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int LW    = 2 + AW + DW + 32;
  localparam int RW    = 1 + AW + DW;

  logic                   clk = 1'b0;
  logic                   resetn = 1'b0;
  logic                   mem_to_wb_valid = 1'b0;
  logic [LANES*LW-1:0]    mem_to_wb_bus = '0;
  logic                   wb_allowin;
  logic [LANES*RW-1:0]    wb_rf_bus;
  logic [31:0]            debug_wb_pc;
  logic [3:0]             debug_wb_rf_we;
  logic [AW-1:0]          debug_wb_rf_wnum;
  logic [DW-1:0]          debug_wb_rf_wdata;

  always #5 clk = ~clk;

  wb_stage_nway #(.LANES(LANES), .DW(DW), .AW(AW)) dut (
    .clk               (clk),
    .resetn            (resetn),
    .mem_to_wb_valid   (mem_to_wb_valid),
    .mem_to_wb_bus     (mem_to_wb_bus),
    .wb_allowin        (wb_allowin),
    .wb_rf_bus         (wb_rf_bus),
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_we    (debug_wb_rf_we),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Bundle currently offered on the input side.
  bit             i_lv [LANES];
  bit             i_we [LANES];
  logic [AW-1:0]  i_wa [LANES];
  logic [DW-1:0]  i_wd [LANES];
  logic [31:0]    i_pc [LANES];

  // Bundle held by the reference WB stage.
  bit             m_valid;
  int             m_pos;
  bit             m_lv [LANES];
  bit             m_we [LANES];
  logic [AW-1:0]  m_wa [LANES];
  logic [DW-1:0]  m_wd [LANES];
  logic [31:0]    m_pc [LANES];

  task automatic set_lane(input int k, input bit lv, input bit we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic [31:0] pcv);
    i_lv[k] = lv; i_we[k] = we; i_wa[k] = wa; i_wd[k] = wd; i_pc[k] = pcv;
    mem_to_wb_bus[k*LW +: LW] = {lv, we, wa, wd, pcv};
  endtask

  function automatic int bundle_cycles();
`ifdef WB_TRACE_SERIAL_EN
    int c = 0;
    for (int k = 0; k < LANES; k++) c += int'(m_lv[k]);
    return (c == 0) ? 1 : c;
`else
    return 1;
`endif
  endfunction

  function automatic bit exp_allowin();
    return !m_valid || (m_pos == bundle_cycles() - 1);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_pos   = 0;
  endtask

  task automatic model_check();
    int  sel;
    int  c;
    bit  kill;
    bit  ew;
    for (int k = 0; k < LANES; k++) begin
      kill = 1'b0;
      for (int j = k + 1; j < LANES; j++)
        if (m_lv[j] && m_we[j] && m_wa[j] == m_wa[k]) kill = 1'b1;
      ew = m_valid && (m_pos == 0) && m_lv[k] && m_we[k] && !kill;
      chk($sformatf("rf_we[%0d]", k), wb_rf_bus[k*RW + RW - 1], ew);
      if (m_valid) begin
        chk($sformatf("rf_waddr[%0d]", k), wb_rf_bus[k*RW + DW +: AW], m_wa[k]);
        chk($sformatf("rf_wdata[%0d]", k), wb_rf_bus[k*RW +: DW], m_wd[k]);
      end
    end
    chk("allowin", wb_allowin, exp_allowin());
    sel = -1;
    c = 0;
    for (int k = 0; k < LANES; k++) c += int'(m_lv[k]);
`ifdef WB_TRACE_SERIAL_EN
    if (m_valid && c > 0) sel = m_pos;
`else
    if (m_valid)
      for (int k = 0; k < LANES; k++) if (m_lv[k] && m_we[k]) sel = k;
`endif
    if (sel >= 0) begin
      chk("dbg_we",    debug_wb_rf_we,    m_we[sel] ? 4'hf : 4'h0);
      chk("dbg_pc",    debug_wb_pc,       m_pc[sel]);
      chk("dbg_wnum",  debug_wb_rf_wnum,  m_wa[sel]);
      chk("dbg_wdata", debug_wb_rf_wdata, m_wd[sel]);
    end else begin
      chk("dbg_we_idle",    debug_wb_rf_we,    0);
      chk("dbg_pc_idle",    debug_wb_pc,       0);
      chk("dbg_wnum_idle",  debug_wb_rf_wnum,  0);
      chk("dbg_wdata_idle", debug_wb_rf_wdata, 0);
    end
  endtask

  task automatic model_step();
    bit al;
    al = exp_allowin();
    if (mem_to_wb_valid && al) begin
      for (int k = 0; k < LANES; k++) begin
        m_lv[k] = i_lv[k]; m_we[k] = i_we[k]; m_wa[k] = i_wa[k];
        m_wd[k] = i_wd[k]; m_pc[k] = i_pc[k];
      end
      m_valid = 1'b1;
      m_pos   = 0;
    end else if (m_valid) begin
      if (al) m_valid = 1'b0;
      else    m_pos++;
    end
  endtask

  // Advance one clock; inputs are changed only at negedge+1.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    #1;
    model_check();
  endtask

  task automatic rand_bundle();
    int c;
    logic [AW-1:0] wa;
    c = $urandom_range(0, LANES);
    for (int k = 0; k < LANES; k++) begin
      case ($urandom % 4)
        0:       wa = 5'd0;
        1:       wa = 5'd4;
        2:       wa = 5'd7;
        default: wa = AW'($urandom);
      endcase
      set_lane(k, k < c, ($urandom % 4) != 0, wa, $urandom, $urandom);
    end
  endtask

  int accepts;

  initial begin
    for (int k = 0; k < LANES; k++) begin
      m_lv[k] = 0; m_we[k] = 0; m_wa[k] = '0; m_wd[k] = '0; m_pc[k] = '0;
      set_lane(k, 0, 0, '0, '0, '0);
    end
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    model_check();
    chk("reset_allowin", wb_allowin, 1);
    chk("reset_dbg_we", debug_wb_rf_we, 0);
    resetn = 1'b1;

    // Two-lane bundle r4 / r5.
    set_lane(0, 1, 1, 5'd4, 32'h11, 32'h1c000000);
    set_lane(1, 1, 1, 5'd5, 32'h22, 32'h1c000004);
    mem_to_wb_valid = 1'b1;
    tick();
    chk("b1_rf_we0", wb_rf_bus[RW-1], 1);
    chk("b1_rf_we1", wb_rf_bus[2*RW-1], 1);
`ifdef WB_TRACE_SERIAL_EN
    chk("b1_c1_wnum", debug_wb_rf_wnum, 4);
    chk("b1_c1_wdata", debug_wb_rf_wdata, 32'h11);
    chk("b1_c1_allowin", wb_allowin, 0);
    mem_to_wb_valid = 1'b0;
`else
    chk("b1_c1_wnum", debug_wb_rf_wnum, 5);
    chk("b1_c1_allowin", wb_allowin, 1);
`endif
    tick();
    chk("b1_c2_pc", debug_wb_pc, 32'h1c000004);
`ifdef WB_TRACE_SERIAL_EN
    chk("b1_c2_wnum", debug_wb_rf_wnum, 5);
    chk("b1_c2_rf_we0", wb_rf_bus[RW-1], 0);
    chk("b1_c2_allowin", wb_allowin, 1);
`else
    chk("b1_again_rf_we0", wb_rf_bus[RW-1], 1);
`endif
    mem_to_wb_valid = 1'b0;
    tick();
    chk("b1_idle_dbg_we", debug_wb_rf_we, 0);

    // Both lanes write r7: youngest wins in the regfile.
    set_lane(0, 1, 1, 5'd7, 32'hAA, 32'h1c000010);
    set_lane(1, 1, 1, 5'd7, 32'hBB, 32'h1c000014);
    mem_to_wb_valid = 1'b1;
    tick();
    mem_to_wb_valid = 1'b0;
    chk("waw_rf_we0", wb_rf_bus[RW-1], 0);
    chk("waw_rf_we1", wb_rf_bus[2*RW-1], 1);
`ifdef WB_TRACE_SERIAL_EN
    chk("waw_c1_wdata", debug_wb_rf_wdata, 32'hAA);
    tick();
    chk("waw_c2_wdata", debug_wb_rf_wdata, 32'hBB);
    chk("waw_c2_rf_we1", wb_rf_bus[2*RW-1], 0);
`else
    chk("waw_c1_wdata", debug_wb_rf_wdata, 32'hBB);
    tick();
    chk("waw_c2_dbg_we", debug_wb_rf_we, 0);
`endif
    tick();

    // Empty bundle (cnt=0).
    set_lane(0, 0, 1, 5'd3, 32'h33, 32'h1c000020);
    set_lane(1, 0, 1, 5'd6, 32'h44, 32'h1c000024);
    mem_to_wb_valid = 1'b1;
    tick();
    mem_to_wb_valid = 1'b0;
    chk("empty_rf_we0", wb_rf_bus[RW-1], 0);
    chk("empty_rf_we1", wb_rf_bus[2*RW-1], 0);
    chk("empty_allowin", wb_allowin, 1);
    chk("empty_dbg_we", debug_wb_rf_we, 0);
    tick();

    // Continuous valid two-lane bundles.
    set_lane(0, 1, 1, 5'd1, 32'h101, 32'h1c000030);
    set_lane(1, 1, 1, 5'd2, 32'h202, 32'h1c000034);
    mem_to_wb_valid = 1'b1;
    accepts = 0;
    repeat (8) begin
      if (wb_allowin) accepts++;
      tick();
    end
`ifdef WB_TRACE_SERIAL_EN
    chk("stream_accepts", accepts, 4);
`else
    chk("stream_accepts", accepts, 8);
`endif
    mem_to_wb_valid = 1'b0;
    repeat (3) tick();

    // Reset in the middle of a bundle.
    set_lane(0, 1, 1, 5'd8, 32'h88, 32'h1c000040);
    set_lane(1, 1, 1, 5'd9, 32'h99, 32'h1c000044);
    mem_to_wb_valid = 1'b1;
    tick();
    mem_to_wb_valid = 1'b0;
`ifdef WB_TRACE_SERIAL_EN
    tick();
`endif
    chk("rst_pre_dbg_we", debug_wb_rf_we, 4'hf);
    resetn = 1'b0;
    #1;
    chk("rst_dbg_we", debug_wb_rf_we, 0);
    chk("rst_allowin", wb_allowin, 1);
    chk("rst_rf_we0", wb_rf_bus[RW-1], 0);
    chk("rst_rf_we1", wb_rf_bus[2*RW-1], 0);
    model_reset();
    model_check();
    @(posedge clk);
    @(negedge clk);
    #1;
    model_check();
    resetn = 1'b1;
    tick();
    chk("post_rst_allowin", wb_allowin, 1);

    // Randomised traffic against the reference model.
    repeat (600) begin
      mem_to_wb_valid = ($urandom % 4) != 0;
      rand_bundle();
      tick();
    end
    mem_to_wb_valid = 1'b0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/wb_stage_nway.md
WB_STAGE_NWAY -- requirements
Module: wb_stage_nway

Interface
REQ-001 Parameter LANES, default 2, number of commit lanes per bundle (legal 1..4).
REQ-002 Parameter DW, default 32, register data width.
REQ-003 Parameter AW, default 5, register address width.
REQ-004 Lane field = {lv, we, waddr[AW], wdata[DW], pc[32]}, LANE_W = 2+AW+DW+32. Lane 0 is the oldest instruction.
REQ-005 clk  input  1  sole clock, rising edge.
REQ-006 resetn  input  1  reset, asynchronous, active-low.
REQ-007 mem_to_wb_valid  input  1  MEM offers a bundle.
REQ-008 mem_to_wb_bus  input  LANES*LANE_W  bundle payload, lane k at bits [k*LANE_W +: LANE_W].
REQ-009 wb_allowin  output  1  WB accepts a bundle this cycle.
REQ-010 wb_rf_bus  output  LANES*(1+AW+DW)  per-lane {we, waddr, wdata} to the regfile and ID bypass.
REQ-011 debug_wb_pc  output  32  trace PC.
REQ-012 debug_wb_rf_we  output  4  trace write enable, replicated.
REQ-013 debug_wb_rf_wnum  output  AW  trace destination register.
REQ-014 debug_wb_rf_wdata  output  DW  trace write data.

Function
REQ-015 Accept when mem_to_wb_valid & wb_allowin. Payload latched on that edge; wb_valid set, else cleared when allowin.
REQ-016 lv bits must be thermometer (lane k valid implies lanes <k valid). cnt = number of set lv bits, 0..LANES.
REQ-017 wb_allowin = ~wb_valid | wb_ready_go.
REQ-018 Index counter idx (width clog2(LANES)+1) reset to 0 on every accept. Increments while wb_valid & ~wb_ready_go.
REQ-019 wb_ready_go = (cnt==0) | (idx==cnt-1). A bundle occupies max(cnt,1) cycles.
REQ-020 Regfile writes for all lanes are issued in the first cycle of a bundle only; flag rf_done is set after that cycle and cleared on accept.
REQ-021 wb_rf_bus lane k we = lv[k] & we[k] & wb_valid & ~rf_done & ~kill[k]. kill[k] is set when any younger valid lane j>k has we[j]=1 and waddr[j]==waddr[k] (youngest write wins).
REQ-022 A write to waddr 0 is passed unchanged; the regfile ignores it.
REQ-023 Trace presents lane idx each cycle while wb_valid & cnt!=0: debug_wb_rf_we = {4{we[idx]}} (unmasked by kill), and pc/wnum/wdata come from lane idx.
REQ-024 When ~wb_valid or cnt==0: debug_wb_rf_we=0, and debug pc/wnum/wdata = 0.
REQ-025 Back-to-back: a new bundle is accepted in the same cycle the last trace lane is shown, with no bubble.
REQ-026 Latency: first regfile write and first trace lane appear in the cycle after accept.

Reset
REQ-027 resetn low asynchronously clears wb_valid, idx and rf_done. Payload registers are not reset.
REQ-028 Values during reset: wb_allowin=1, all wb_rf_bus we=0, all debug outputs 0.
REQ-029 Reset mid-bundle discards the remaining trace lanes. No regfile write occurs after reset asserts.

Configuration
REQ-030 Macro WB_TRACE_SERIAL_EN.
- Defined: behaviour as REQ-018..REQ-025.
- Undefined: wb_ready_go=1 and every bundle takes one cycle. Debug outputs carry the youngest valid lane whose we=1, else 0. idx logic is removed.

Structure
REQ-031 Package wb_pkg holds the LANE_W localparam and per-field offset constants, shared with mem_stage and id_stage.
REQ-032 Sub-module wb_waw_mask computes kill[LANES-1:0] combinationally from the per-lane we/waddr/lv inputs.

Verification
REQ-033 LANES=2, bundle lanes {pc 0x1c000000 r4=0x11, pc 0x1c000004 r5=0x22}:
- rf we on both lanes in cycle 1.
- Trace shows r4 in cycle 1 and r5 in cycle 2.
- wb_allowin=0 in cycle 1.
REQ-034 Both lanes write r7 (0xAA then 0xBB): only lane 1 rf we is asserted; the trace shows both writes in order.
REQ-035 Continuous valid 2-lane bundles: one accept every 2 cycles, no gap in the trace, no duplicate regfile write.
REQ-036 Bundle with cnt=0 accepted: one cycle, all we=0, wb_allowin stays 1.
REQ-037 resetn dropped in cycle 2 of a 2-lane bundle: debug_wb_rf_we=0 immediately; wb_allowin=1 after reset.
REQ-038 WB_TRACE_SERIAL_EN undefined, 2-lane bundle: accepted every cycle; trace shows lane 1 only.
